ram_rw_2p_param: RTL and testbench

Parametrised true dual-port synchronous RAM, the next-generation CPU memory. Both ports can independently read or write any word. The block adds a hardware zero-fill sequence after reset, same-cycle write-to-read forwarding and deterministic write-collision resolution. A configurable low-bit mask on the port-1 read path keeps the "load least-significant bits only" behaviour without hard-coding 7 bits.

---
 rtl/ram_rw_2p_param.sv | 132 +++++++++++++
 tb/tb_ram_rw_2p_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_rw_2p_param.sv
// True dual-port synchronous RAM with post-reset zero-fill,
// write-first forwarding and port-1 collision priority.
module ram_rw_2p_param #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 7,
  parameter int P1_MASK_W     = 7,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic              read_en0,
  input  logic              write_en0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  output logic [DATA_W-1:0] dout0,
  output logic              rvalid0,
  input  logic              read_en1,
  input  logic              write_en1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  output logic [DATA_W-1:0] dout1,
  output logic              rvalid1,
  output logic              wr_collide
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  localparam logic [DATA_W:0] MASK_EXT =
    ((DATA_W+1)'(1) << P1_MASK_W) - (DATA_W+1)'(1);
  localparam logic [DATA_W-1:0] P1_MASK = MASK_EXT[DATA_W-1:0];

  typedef enum logic [1:0] {
    ST_RESET,
    ST_FILL,
    ST_RUN
  } state_t;

  localparam state_t ST_INIT = INIT_ON_RESET ? ST_RESET : ST_RUN;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic fill_we;
  logic run;

  logic [DATA_W-1:0] mem [DEPTH];

  logic rd0, wr0, rd1, wr1;
  logic fwd0, fwd1;
  logic [DATA_W-1:0] rdata0, rdata1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // RESET doubles as the first fill step so address 0 is cleared
  // on the first edge after release.
  always_comb begin
    state_d = state_q;
    fill_we = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      ST_RESET, ST_FILL: begin
        fill_we = 1'b1;
        state_d = (cnt_q == LAST) ? ST_RUN : ST_FILL;
      end
      ST_RUN: run = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  assign init_busy = ~run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (fill_we) cnt_q <= cnt_q + ADDR_W'(1);
  end

  always_comb begin
    rd0 = 1'b0;
    wr0 = 1'b0;
    rd1 = 1'b0;
    wr1 = 1'b0;
    if (run) begin
      unique case (1'b1)
        (read_en0 & ~write_en0): rd0 = 1'b1;
        (write_en0 & ~read_en0): wr0 = 1'b1;
        default: ;
      endcase
      unique case (1'b1)
        (read_en1 & ~write_en1): rd1 = 1'b1;
        (write_en1 & ~read_en1): wr1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign fwd0 = wr1 && (addr1 == addr0);
  assign fwd1 = wr0 && (addr0 == addr1);

  assign rdata0 = fwd0 ? din1 : mem[addr0];
  assign rdata1 = fwd1 ? din0 : mem[addr1];

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr0) mem[addr0] <= din0;
      if (wr1) mem[addr1] <= din1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout0      <= '0;
      dout1      <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      wr_collide <= 1'b0;
    end else begin
      rvalid0    <= rd0;
      rvalid1    <= rd1;
      wr_collide <= wr0 & wr1 & (addr0 == addr1);
      if (rd0) dout0 <= rdata0;
      if (rd1) dout1 <= rdata1 & P1_MASK;
    end
  end

endmodule

// File: tb/tb_ram_rw_2p_param.sv
// Directed bench for ram_rw_2p_param: fill, R/W, mask,
// collision, forwarding, illegal strobes and mid-fill reset.
module tb_ram_rw_2p_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_en0, write_en0, read_en1, write_en1;
  logic [6:0]  addr0, addr1;
  logic [15:0] din0, din1;

  logic        init_busy, rvalid0, rvalid1, wr_collide;
  logic [15:0] dout0, dout1;
  logic        init_busy_w, rvalid0_w, rvalid1_w, wr_collide_w;
  logic [15:0] dout0_w, dout1_w;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  ram_rw_2p_param u_dut (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
    .read_en0(read_en0), .write_en0(write_en0),
    .addr0(addr0), .din0(din0), .dout0(dout0), .rvalid0(rvalid0),
    .read_en1(read_en1), .write_en1(write_en1),
    .addr1(addr1), .din1(din1), .dout1(dout1), .rvalid1(rvalid1),
    .wr_collide(wr_collide)
  );

  ram_rw_2p_param #(.P1_MASK_W(16)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy_w),
    .read_en0(read_en0), .write_en0(write_en0),
    .addr0(addr0), .din0(din0), .dout0(dout0_w), .rvalid0(rvalid0_w),
    .read_en1(read_en1), .write_en1(write_en1),
    .addr1(addr1), .din1(din1), .dout1(dout1_w), .rvalid1(rvalid1_w),
    .wr_collide(wr_collide_w)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_en0 = 0; write_en0 = 0; read_en1 = 0; write_en1 = 0;
  endtask

  task automatic rd0(input logic [6:0] a);
    read_en0 = 1; addr0 = a;
    step();
    idle();
  endtask

  task automatic rd1(input logic [6:0] a);
    read_en1 = 1; addr1 = a;
    step();
    idle();
  endtask

  task automatic wait_fill(input string tag, input int drop_at);
    n = 0;
    while (init_busy && n < 300) begin
      if (n == drop_at) begin
        write_en0 = 1; addr0 = 7'd10; din0 = 16'hFFFF;
      end
      step();
      idle();
      n++;
    end
    chk(tag, n, 128);
  endtask

  initial begin
    idle();
    addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_busy", init_busy, 1);
    chk("rst_dout0", dout0, 0);
    chk("rst_dout1", dout1, 0);
    chk("rst_rv0", rvalid0, 0);
    chk("rst_rv1", rvalid1, 0);
    chk("rst_coll", wr_collide, 0);

    rst_n = 1'b1;
    wait_fill("fill_len", 50);
    chk("fill_len_w", init_busy_w, 0);

    rd0(7'd0);
    chk("z0", dout0, 0); chk("z0_rv", rvalid0, 1);
    rd0(7'd64);
    chk("z64", dout0, 0); chk("z64_rv", rvalid0, 1);
    rd0(7'd127);
    chk("z127", dout0, 0); chk("z127_rv", rvalid0, 1);
    step();
    chk("rv_drop", rvalid0, 0);
    rd0(7'd10);
    chk("fill_drop", dout0, 0);

    write_en0 = 1; addr0 = 7'd5; din0 = 16'hBEEF;
    step(); idle();
    chk("wr_norv", rvalid0, 0);
    rd0(7'd5);
    chk("rw5", dout0, 16'hBEEF);
    rd1(7'd5);
    chk("mask7", dout1, 16'h006F);
    chk("mask7_rv", rvalid1, 1);
    chk("mask16", dout1_w, 16'hBEEF);

    write_en0 = 1; addr0 = 7'd9; din0 = 16'h1111;
    write_en1 = 1; addr1 = 7'd9; din1 = 16'h2222;
    step(); idle();
    chk("coll", wr_collide, 1);
    step();
    chk("coll_drop", wr_collide, 0);
    rd0(7'd9);
    chk("coll_win", dout0, 16'h2222);

    write_en1 = 1; addr1 = 7'd3; din1 = 16'hA5A5;
    read_en0 = 1; addr0 = 7'd3;
    step(); idle();
    chk("fwd0", dout0, 16'hA5A5);
    chk("fwd0_rv", rvalid0, 1);
    write_en0 = 1; addr0 = 7'd4; din0 = 16'h00C3;
    read_en1 = 1; addr1 = 7'd4;
    step(); idle();
    chk("fwd1", dout1, 16'h0043);
    chk("fwd1_w", dout1_w, 16'h00C3);

    read_en0 = 1; addr0 = 7'd5;
    step();
    chk("b2b_a", dout0, 16'hBEEF);
    addr0 = 7'd3;
    step(); idle();
    chk("b2b_b", dout0, 16'hA5A5);
    chk("b2b_rv", rvalid0, 1);

    rd0(7'd5);
    chk("hold_pre", dout0, 16'hBEEF);
    read_en0 = 1; write_en0 = 1; addr0 = 7'd5; din0 = 16'h1234;
    step(); idle();
    chk("ill_rv", rvalid0, 0);
    chk("ill_hold", dout0, 16'hBEEF);
    rd1(7'd5);
    chk("ill_nowr", dout1_w, 16'hBEEF);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout0", dout0, 0);
    chk("arst_dout1w", dout1_w, 0);
    chk("arst_busy", init_busy, 1);
    step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("mid_busy", init_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", init_busy, 1);
    chk("mid_rst_rv", rvalid0, 0);
    step();
    rst_n = 1'b1;
    wait_fill("refill_len", -1);
    rd0(7'd5);
    chk("refill5", dout0, 0);
    chk("refill5_rv", rvalid0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
